peridot_i2c_seq: RTL and testbench

//  Command sequencer that sits upstream of the PERIDOT I2C master and drives its 2-register Avalon-MM slave.
//  - Buffers byte commands in a FIFO.
//  - Brings the master out of devrst and programs clkdiv.
//  - Issues each command, polls ready, and returns {nack,rxdata} on a response stream.
//  - Lets a Nios/stream source queue a whole I2C transaction without per-byte CPU polling.

---
 rtl/peridot_i2c_seq.sv | 198 +++++++++++++++++++
 tb/tb_peridot_i2c_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peridot_i2c_seq.sv
// Command sequencer for the PERIDOT I2C master. It buffers byte commands,
// brings the master out of devrst, programs clkdiv, then issues each command
// over the master's 2-register Avalon-MM slave. It returns one {nack,rxdata}
// response per command.
module peridot_i2c_seq #(
  parameter int unsigned CMD_FIFO_AW = 4,
  parameter logic [9:0]  CLKDIV      = 10'd124,
  parameter int unsigned POLL_GAP    = 4
) (
  input  logic                   csi_clk,
  input  logic                   rsi_reset,
  input  logic                   asi_cmd_valid,
  output logic                   asi_cmd_ready,
  input  logic [11:0]            asi_cmd_data,
  output logic                   aso_rsp_valid,
  input  logic                   aso_rsp_ready,
  output logic [8:0]             aso_rsp_data,
  output logic                   avm_address,
  output logic                   avm_read,
  input  logic [31:0]            avm_readdata,
  output logic                   avm_write,
  output logic [31:0]            avm_writedata,
  output logic                   cfg_done,
  output logic                   busy,
  output logic [CMD_FIFO_AW:0]   cmd_level
);

  localparam int unsigned            Depth    = 2 ** CMD_FIFO_AW;
  localparam logic [7:0]             GapLoad  = 8'(POLL_GAP);
  localparam logic [CMD_FIFO_AW:0]   DepthLvl = (CMD_FIFO_AW + 1)'(Depth);
  localparam logic [CMD_FIFO_AW:0]   LvlOne   = (CMD_FIFO_AW + 1)'(1);
  localparam logic [CMD_FIFO_AW-1:0] PtrOne   = CMD_FIFO_AW'(1);
  // reg01: devrst (bit 15) cleared, clkdiv in bits 9:0.
  localparam logic [31:0]            Reg01Cfg = {16'b0, 1'b0, 5'b0, CLKDIV};

  typedef enum logic [2:0] {
    StCfgRst, StCfgPoll, StCfgDiv, StIdle, StIssue, StGap, StPoll, StResp
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [11:0]            mem_q [Depth];
  logic [CMD_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CMD_FIFO_AW:0]   level_q, level_d;
  logic                   push, pop;
  logic [11:0]            head;
  logic                   rd_q, rd_d, wr_q, wr_d, addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [8:0]             rsp_data_q, rsp_data_d;
  logic                   cfg_done_q, cfg_done_d;
  logic                   busy_q, busy_d;
  logic                   cmd_ready_q, cmd_ready_d;

  assign push = asi_cmd_valid & cmd_ready_q;
  assign head = mem_q[rd_ptr_q];

  assign level_d = level_q + (push ? LvlOne : '0) - (pop ? LvlOne : '0);
  // Status outputs are registered so every output reads 0 while in reset.
  assign busy_d      = (state_d != StIdle) || (level_d != '0);
  assign cmd_ready_d = (level_d != DepthLvl);

  // Command storage; no reset needed, emptiness is tracked by the pointers.
  always_ff @(posedge csi_clk) begin
    if (push) mem_q[wr_ptr_q] <= asi_cmd_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      level_q <= level_d;
    end
  end

  // Next state and next registered bus/stream outputs. Strobes are one-shot
  // because the default every cycle is 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = 1'b0;
    wdata_d     = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    cfg_done_d  = cfg_done_q;
    pop         = 1'b0;
    unique case (state_q)
      StCfgRst: begin
        wr_d    = 1'b1;
        addr_d  = 1'b1;
        wdata_d = Reg01Cfg;
        cnt_d   = GapLoad;
        state_d = StCfgPoll;
      end
      StCfgPoll: begin
        // avm_read high means this cycle's readdata answers our poll.
        if (avm_read && avm_readdata[9]) begin
          state_d = StCfgDiv;
        end else if (cnt_q == 8'd0) begin
          rd_d  = 1'b1;
          cnt_d = GapLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCfgDiv: begin
        wr_d       = 1'b1;
        addr_d     = 1'b1;
        wdata_d    = Reg01Cfg;
        cfg_done_d = 1'b1;
        state_d    = StIdle;
      end
      StIdle: begin
        if (level_q != '0) state_d = StIssue;
      end
      StIssue: begin
        pop     = 1'b1;
        wr_d    = 1'b1;
        wdata_d = {16'b0, 1'b0, 2'b0, head[11:9], 1'b1, head[8:0]};
        cnt_d   = GapLoad;
        state_d = StGap;
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          rd_d    = 1'b1;
          state_d = StPoll;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StPoll: begin
        if (avm_readdata[9]) begin
          rsp_data_d  = avm_readdata[8:0];
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d   = GapLoad;
          state_d = StGap;
        end
      end
      StResp: begin
        if (aso_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StCfgRst;
    endcase
  end

  // State and output registers.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q     <= StCfgRst;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cfg_done_q  <= cfg_done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign asi_cmd_ready = cmd_ready_q;
  assign aso_rsp_valid = rsp_valid_q;
  assign aso_rsp_data  = rsp_data_q;
  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;
  assign cfg_done      = cfg_done_q;
  assign busy          = busy_q;
  assign cmd_level     = level_q;

endmodule

// File: tb/tb_peridot_i2c_seq.sv
// Bench for peridot_i2c_seq: behavioural PERIDOT master model plus scoreboards
// of expected Avalon writes and expected responses.
`timescale 1ns/1ps
module tb_peridot_i2c_seq;

  localparam int unsigned AW = 4;

  logic          csi_clk = 1'b0;
  logic          rsi_reset = 1'b1;
  logic          asi_cmd_valid, asi_cmd_ready;
  logic [11:0]   asi_cmd_data;
  logic          aso_rsp_valid, aso_rsp_ready;
  logic [8:0]    aso_rsp_data;
  logic          avm_address, avm_read, avm_write;
  logic [31:0]   avm_readdata, avm_writedata;
  logic          cfg_done, busy;
  logic [AW:0]   cmd_level;

  always #5 csi_clk = ~csi_clk;

  peridot_i2c_seq #(
    .CMD_FIFO_AW(AW),
    .CLKDIV     (10'd124),
    .POLL_GAP   (4)
  ) dut (
    .csi_clk      (csi_clk),
    .rsi_reset    (rsi_reset),
    .asi_cmd_valid(asi_cmd_valid),
    .asi_cmd_ready(asi_cmd_ready),
    .asi_cmd_data (asi_cmd_data),
    .aso_rsp_valid(aso_rsp_valid),
    .aso_rsp_ready(aso_rsp_ready),
    .aso_rsp_data (aso_rsp_data),
    .avm_address  (avm_address),
    .avm_read     (avm_read),
    .avm_readdata (avm_readdata),
    .avm_write    (avm_write),
    .avm_writedata(avm_writedata),
    .cfg_done     (cfg_done),
    .busy         (busy),
    .cmd_level    (cmd_level)
  );

  typedef struct {
    int         lat;
    logic [8:0] rsp;
  } mrsp_t;

  mrsp_t       model_q[$];
  logic [32:0] exp_wr_q[$];   // {address, writedata}
  logic [8:0]  exp_rsp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          rsp_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model: devrst held by reset, ready 30 cycles after release,
  // ready drops the cycle after a start write and returns after 'lat' cycles.
  logic       m_devrst, m_ready, m_busy;
  logic [8:0] m_data, m_next;
  int         m_cnt, m_rel;

  assign avm_readdata = {22'd0, m_ready, m_data};

  always @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      m_devrst <= 1'b1;
      m_ready  <= 1'b0;
      m_busy   <= 1'b0;
      m_data   <= '0;
      m_next   <= '0;
      m_cnt    <= 0;
      m_rel    <= 0;
    end else begin
      if (avm_write && avm_address) begin
        if (avm_writedata[15]) begin
          m_devrst <= 1'b1;
          m_ready  <= 1'b0;
        end else if (m_devrst) begin
          m_devrst <= 1'b0;
          m_rel    <= 30;
        end
      end else if (m_rel > 0) begin
        m_rel <= m_rel - 1;
        if (m_rel == 1) m_ready <= 1'b1;
      end
      if (avm_write && !avm_address && avm_writedata[9] && m_ready && model_q.size() > 0) begin
        m_ready <= 1'b0;
        m_busy  <= 1'b1;
        m_cnt   <= model_q[0].lat;
        m_next  <= model_q[0].rsp;
        model_q.pop_front();
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt <= 1) begin
          m_busy  <= 1'b0;
          m_ready <= 1'b1;
          m_data  <= m_next;
        end
      end
    end
  end

  // Bus and response monitor, sampled on the falling edge.
  logic        prev_wr, prev_rd;
  logic [32:0] e_wr;
  always @(negedge csi_clk) begin
    if (rsi_reset) begin
      prev_wr = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (avm_read || avm_write) begin
        check_eq("rd_wr_excl", 64'(avm_read & avm_write), 64'd0);
        check_eq("strobe_1cyc", 64'((avm_write & prev_wr) | (avm_read & prev_rd)), 64'd0);
      end
      if (avm_write) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) begin
          check_eq("wr_unexpected", 64'({avm_address, avm_writedata}), 64'hDEAD_0000_0000);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check_eq("wr_addr_data", 64'({avm_address, avm_writedata}), 64'(e_wr));
          if (!avm_address) begin
            check_eq("issue_after_cfg", 64'(cfg_done), 64'd1);
            check_eq("issue_when_ready", 64'(m_ready), 64'd1);
          end
        end
      end
      if (aso_rsp_valid && aso_rsp_ready) begin
        rsp_cnt++;
        if (exp_rsp_q.size() == 0) check_eq("rsp_unexpected", 64'(aso_rsp_data), 64'hDEAD);
        else check_eq("rsp_data", 64'(aso_rsp_data), 64'(exp_rsp_q.pop_front()));
      end
      prev_wr = avm_write;
      prev_rd = avm_read;
    end
  end

  task automatic do_reset();
    rsi_reset     = 1'b1;
    asi_cmd_valid = 1'b0;
    exp_wr_q.delete();
    exp_rsp_q.delete();
    model_q.delete();
    exp_wr_q.push_back({1'b1, 32'h0000_007C});
    exp_wr_q.push_back({1'b1, 32'h0000_007C});
    repeat (3) @(posedge csi_clk);
    #1;
    rsi_reset = 1'b0;
  endtask

  task automatic push_cmd(input logic [11:0] cmd, input int lat, input logic [8:0] rsp);
    int t   = 0;
    bit acc = 1'b0;
    asi_cmd_valid = 1'b1;
    asi_cmd_data  = cmd;
    while (!acc && t < 3000) begin
      @(negedge csi_clk);
      acc = asi_cmd_ready;
      @(posedge csi_clk);
      #1;
      t++;
    end
    asi_cmd_valid = 1'b0;
    check_eq("push_accept", 64'(acc), 64'd1);
    if (acc) begin
      // {irqena=0, 2'b0, sta, stp, rd_nwr, start=1, nack, txdata}
      exp_wr_q.push_back({1'b0, 16'h0, 1'b0, 2'b0, cmd[11], cmd[10], cmd[9], 1'b1,
                          cmd[8], cmd[7:0]});
      exp_rsp_q.push_back(rsp);
      model_q.push_back('{lat, rsp});
    end
  endtask

  task automatic wait_rsp(input int target, input int budget, input string tag);
    int t = 0;
    while (rsp_cnt < target && t < budget) begin
      @(posedge csi_clk);
      #1;
      t++;
    end
    check_eq(tag, 64'(rsp_cnt), 64'(target));
  endtask

  task automatic wait_cfg(input string tag);
    int t = 0;
    while (!cfg_done && t < 1000) begin
      @(posedge csi_clk);
      #1;
      t++;
    end
    check_eq(tag, 64'(cfg_done), 64'd1);
  endtask

  // Random command plus the response the model will give for it.
  task automatic rand_cmd(output logic [11:0] cmd, output logic [8:0] rsp);
    logic [31:0] r;
    r   = $urandom;
    cmd = r[11:0];
    if (cmd[9]) rsp = {cmd[8], r[23:16]};   // read: nack sent, received byte
    else        rsp = {r[24], cmd[7:0]};    // write: slave ack, bus echo
  endtask

  int          base, base_wr, t;
  logic [8:0]  hold_data;
  bit          stable;
  logic [11:0] c;
  logic [8:0]  r;

  initial begin
    asi_cmd_valid = 1'b0;
    asi_cmd_data  = '0;
    aso_rsp_ready = 1'b1;
    #1;
    check_eq("reset_outputs", 64'({asi_cmd_ready, aso_rsp_valid, aso_rsp_data, avm_address,
             avm_read, avm_write, avm_writedata, cfg_done, busy, cmd_level}), 64'd0);
    do_reset();

    // 1: init sequence with an empty FIFO
    wait_cfg("t1_cfg_done");
    repeat (50) @(posedge csi_clk);
    #1;
    check_eq("t1_wr_count", 64'(wr_cnt), 64'd2);
    check_eq("t1_level", 64'(cmd_level), 64'd0);
    check_eq("t1_busy", 64'(busy), 64'd0);
    check_eq("t1_wr_drained", 64'(exp_wr_q.size()), 64'd0);

    // 2: write command, ACK after 50 cycles
    push_cmd(12'hCA0, 50, 9'h0A0);
    wait_rsp(1, 1000, "t2_rsp");

    // 3: read command with stp, rd, nack
    push_cmd(12'h700, 30, 9'h15B);
    wait_rsp(2, 1000, "t3_rsp");

    // 4: fill the FIFO during init
    do_reset();
    base = rsp_cnt;
    for (int i = 0; i < 16; i++) begin
      rand_cmd(c, r);
      push_cmd(c, int'($urandom_range(5, 40)), r);
    end
    check_eq("t4_level_full", 64'(cmd_level), 64'd16);
    check_eq("t4_ready_low", 64'(asi_cmd_ready), 64'd0);
    check_eq("t4_not_cfg", 64'(cfg_done), 64'd0);
    rand_cmd(c, r);
    push_cmd(c, 10, r);
    wait_rsp(base + 17, 8000, "t4_all_rsp");

    // 5: response backpressure stalls further issues
    aso_rsp_ready = 1'b0;
    base = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      rand_cmd(c, r);
      push_cmd(c, int'($urandom_range(5, 20)), r);
    end
    t = 0;
    while (!aso_rsp_valid && t < 1000) begin
      @(posedge csi_clk);
      #1;
      t++;
    end
    check_eq("t5_valid", 64'(aso_rsp_valid), 64'd1);
    hold_data = aso_rsp_data;
    base_wr   = wr_cnt;
    stable    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge csi_clk);
      #1;
      if (aso_rsp_data !== hold_data || aso_rsp_valid !== 1'b1) stable = 1'b0;
    end
    check_eq("t5_stable", 64'(stable), 64'd1);
    check_eq("t5_no_wr", 64'(wr_cnt), 64'(base_wr));
    check_eq("t5_level", 64'(cmd_level), 64'd2);
    aso_rsp_ready = 1'b1;
    wait_rsp(base + 3, 2000, "t5_rsp");

    // 6: reset while polling
    base_wr = wr_cnt;
    push_cmd(12'hC55, 200, 9'h055);
    t = 0;
    while (wr_cnt == base_wr && t < 500) begin
      @(posedge csi_clk);
      #1;
      t++;
    end
    t = 0;
    while (!avm_read && t < 500) begin
      @(posedge csi_clk);
      #1;
      t++;
    end
    check_eq("t6_in_poll", 64'(avm_read), 64'd1);
    rsi_reset = 1'b1;
    #1;
    check_eq("t6_reset_outputs", 64'({asi_cmd_ready, aso_rsp_valid, aso_rsp_data, avm_address,
             avm_read, avm_write, avm_writedata, cfg_done, busy, cmd_level}), 64'd0);
    base_wr = wr_cnt;
    do_reset();
    wait_cfg("t6_cfg_again");
    #20;
    check_eq("t6_init_writes", 64'(wr_cnt), 64'(base_wr + 2));
    base = rsp_cnt;
    push_cmd(12'h2A7, 15, 9'h13C);
    wait_rsp(base + 1, 1000, "t6_rsp_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
